// File: rtl/mycpu_pkg.sv
// Shared encodings for the MEM-side pipeline stages.
// Load operation codes and the MEM wait-stage state machine.
package mycpu_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_B    = 3'd1;
    localparam logic [2:0] LD_BU   = 3'd2;
    localparam logic [2:0] LD_H    = 3'd3;
    localparam logic [2:0] LD_HU   = 3'd4;
    localparam logic [2:0] LD_W    = 3'd5;
    localparam logic [2:0] LD_WU   = 3'd6;
    localparam logic [2:0] LD_D    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } mem_state_e;

endpackage

// File: rtl/mem_wait_stage_if.sv
// EX -> MEM -> WB handshake bundle around the MEM wait stage.
// master is the stage side, slave is the surrounding pipeline.
interface mem_wait_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
);
    logic              ex_to_mem_valid;
    logic              mem_allowin;
    logic              ex_rf_we;
    logic [4:0]        ex_rf_waddr;
    logic [PC_W-1:0]   ex_pc;
    logic [DATA_W-1:0] ex_alu_result;
    logic [2:0]        ex_ld_op;
    logic              ex_req_sent;
    logic              mem_flush;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;
    logic              wb_allowin;
    logic              mem_to_wb_valid;
    logic              mem_to_wb_we;
    logic [4:0]        mem_to_wb_waddr;
    logic [DATA_W-1:0] mem_to_wb_wdata;
    logic [PC_W-1:0]   mem_to_wb_pc;
    logic [DATA_W+6:0] mem_rf_zip;

    modport master (
        input  ex_to_mem_valid, ex_rf_we, ex_rf_waddr,
        input  ex_pc, ex_alu_result, ex_ld_op, ex_req_sent,
        input  mem_flush, data_sram_data_ok, data_sram_rdata,
        input  wb_allowin,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_we,
        output mem_to_wb_waddr, mem_to_wb_wdata, mem_to_wb_pc,
        output mem_rf_zip
    );

    modport slave (
        output ex_to_mem_valid, ex_rf_we, ex_rf_waddr,
        output ex_pc, ex_alu_result, ex_ld_op, ex_req_sent,
        output mem_flush, data_sram_data_ok, data_sram_rdata,
        output wb_allowin,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_we,
        input  mem_to_wb_waddr, mem_to_wb_wdata, mem_to_wb_pc,
        input  mem_rf_zip
    );
endinterface

// File: rtl/load_align.sv
// Load data alignment: shift by the byte offset, then
// sign- or zero-extend according to the load op.
module load_align
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int OFF_W = (DATA_W == 64) ? 3 : 2
) (
    input  logic [2:0]        ld_op,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] ld_data
);

    logic [DATA_W-1:0] sh;

    function automatic logic [DATA_W-1:0] sx(
        input logic [DATA_W-1:0] v,
        input int n
    );
        return $signed(v << (DATA_W - n)) >>> (DATA_W - n);
    endfunction

    function automatic logic [DATA_W-1:0] zx(
        input logic [DATA_W-1:0] v,
        input int n
    );
        return (v << (DATA_W - n)) >> (DATA_W - n);
    endfunction

    assign sh = raw >> {off, 3'b000};

    always_comb begin
        ld_data = sh;
        case (ld_op)
            LD_B:    ld_data = sx(sh, 8);
            LD_BU:   ld_data = zx(sh, 8);
            LD_H:    ld_data = sx(sh, 16);
            LD_HU:   ld_data = zx(sh, 16);
            LD_W:    ld_data = sx(sh, 32);
            LD_WU:   ld_data = zx(sh, 32);
            default: ld_data = sh;
        endcase
    end

endmodule

// File: rtl/mem_wait_stage.sv
// MEM stage that waits for data_ok, buffers load data when WB
// stalls, and drains a response still owed after a flush.
module mem_wait_stage
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ex_to_mem_valid,
    output logic              mem_allowin,
    input  logic              ex_rf_we,
    input  logic [4:0]        ex_rf_waddr,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [2:0]        ex_ld_op,
    input  logic              ex_req_sent,
    input  logic              mem_flush,
    input  logic              data_sram_data_ok,
    input  logic [DATA_W-1:0] data_sram_rdata,
    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    output logic              mem_to_wb_we,
    output logic [4:0]        mem_to_wb_waddr,
    output logic [DATA_W-1:0] mem_to_wb_wdata,
    output logic [PC_W-1:0]   mem_to_wb_pc,
    output logic [DATA_W+6:0] mem_rf_zip
);

    localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

    mem_state_e state, nxt, acc_st;

    logic              r_we;
    logic [4:0]        r_waddr;
    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_alu;
    logic [2:0]        r_op;
    logic [DATA_W-1:0] buf_q;
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ext;
    logic              accept;
    logic              ok;
    logic              slot_v;
    logic              pend;

    assign ok = data_sram_data_ok;

    assign mem_to_wb_valid = (state == S_RUN)
                           | (state == S_HOLD)
                           | ((state == S_WAIT) & ok);

    assign mem_allowin = (state == S_IDLE)
                       | (mem_to_wb_valid & wb_allowin);

    assign accept = ex_to_mem_valid & mem_allowin & ~mem_flush;
    assign acc_st = ex_req_sent ? S_WAIT : S_RUN;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nxt;
    end

    // data_ok arriving with the flush means nothing is owed any more
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:
                if (accept) nxt = acc_st;
            S_RUN, S_HOLD:
                if (mem_flush)       nxt = S_IDLE;
                else if (wb_allowin) nxt = accept ? acc_st : S_IDLE;
            S_WAIT:
                if (mem_flush)     nxt = ok ? S_IDLE : S_DRAIN;
                else if (ok)       nxt = !wb_allowin ? S_HOLD :
                                         accept ? acc_st : S_IDLE;
            S_DRAIN:
                if (ok) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_pc    <= '0;
            r_alu   <= '0;
            r_op    <= LD_NONE;
            buf_q   <= '0;
        end else begin
            if (accept) begin
                r_we    <= ex_rf_we;
                r_waddr <= ex_rf_waddr;
                r_pc    <= ex_pc;
                r_alu   <= ex_alu_result;
                r_op    <= ex_ld_op;
            end
            if ((state == S_WAIT) & ok & ~wb_allowin & ~mem_flush)
                buf_q <= data_sram_rdata;
        end
    end

    assign raw = (state == S_HOLD) ? buf_q : data_sram_rdata;

    load_align #(.DATA_W(DATA_W)) u_align (
        .ld_op   (r_op),
        .off     (r_alu[OFF_W-1:0]),
        .raw     (raw),
        .ld_data (ext)
    );

    assign mem_to_wb_we    = r_we;
    assign mem_to_wb_waddr = r_waddr;
    assign mem_to_wb_pc    = r_pc;
    assign mem_to_wb_wdata = (r_op != LD_NONE) ? ext : r_alu;

    assign slot_v = (state == S_RUN)
                  | (state == S_WAIT)
                  | (state == S_HOLD);
    assign pend   = (state == S_WAIT) | (state == S_HOLD);

    assign mem_rf_zip = slot_v ?
        {r_we, pend, r_waddr, mem_to_wb_wdata} : '0;

endmodule

// File: tb/tb_mem_wait_stage.sv
// Randomized scoreboard bench for mem_wait_stage with a
// slot-level reference model and a small 64-bit load table.
module tb_mem_wait_stage;
    import mycpu_pkg::*;

    localparam int DW = 32;
    localparam int PW = 32;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    mem_wait_stage_if #(.DATA_W(DW), .PC_W(PW)) bus();

    mem_wait_stage #(.DATA_W(DW), .PC_W(PW)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_to_mem_valid   (bus.ex_to_mem_valid),
        .mem_allowin       (bus.mem_allowin),
        .ex_rf_we          (bus.ex_rf_we),
        .ex_rf_waddr       (bus.ex_rf_waddr),
        .ex_pc             (bus.ex_pc),
        .ex_alu_result     (bus.ex_alu_result),
        .ex_ld_op          (bus.ex_ld_op),
        .ex_req_sent       (bus.ex_req_sent),
        .mem_flush         (bus.mem_flush),
        .data_sram_data_ok (bus.data_sram_data_ok),
        .data_sram_rdata   (bus.data_sram_rdata),
        .wb_allowin        (bus.wb_allowin),
        .mem_to_wb_valid   (bus.mem_to_wb_valid),
        .mem_to_wb_we      (bus.mem_to_wb_we),
        .mem_to_wb_waddr   (bus.mem_to_wb_waddr),
        .mem_to_wb_wdata   (bus.mem_to_wb_wdata),
        .mem_to_wb_pc      (bus.mem_to_wb_pc),
        .mem_rf_zip        (bus.mem_rf_zip)
    );

    logic        e_valid, e_ok, e_req;
    logic [2:0]  e_op;
    logic [63:0] e_alu, e_rdata;
    logic        o_allow, o_valid, o_we;
    logic [4:0]  o_waddr;
    logic [63:0] o_wdata;
    logic [31:0] o_pc;
    logic [70:0] o_zip;

    mem_wait_stage #(.DATA_W(64), .PC_W(32)) dut64 (
        .clk               (clk),
        .resetn            (resetn),
        .ex_to_mem_valid   (e_valid),
        .mem_allowin       (o_allow),
        .ex_rf_we          (1'b1),
        .ex_rf_waddr       (5'd3),
        .ex_pc             (32'h1c00_0000),
        .ex_alu_result     (e_alu),
        .ex_ld_op          (e_op),
        .ex_req_sent       (e_req),
        .mem_flush         (1'b0),
        .data_sram_data_ok (e_ok),
        .data_sram_rdata   (e_rdata),
        .wb_allowin        (1'b1),
        .mem_to_wb_valid   (o_valid),
        .mem_to_wb_we      (o_we),
        .mem_to_wb_waddr   (o_waddr),
        .mem_to_wb_wdata   (o_wdata),
        .mem_to_wb_pc      (o_pc),
        .mem_rf_zip        (o_zip)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string nm, logic [63:0] act,
                       logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    typedef struct {
        logic          we;
        logic [4:0]    waddr;
        logic [PW-1:0] pc;
        logic [DW-1:0] wdata;
    } exp_t;

    exp_t q[$];

    function automatic int op_bytes(logic [2:0] op);
        case (op)
            LD_B, LD_BU: return 1;
            LD_H, LD_HU: return 2;
            default:     return 4;
        endcase
    endfunction

    // Byte-level view of a load: pick n bytes, extend the top one
    function automatic logic [DW-1:0] ld_model(
        logic [2:0] op, logic [DW-1:0] data, int off);
        int n;
        bit sgn;
        logic [63:0] v;
        n = op_bytes(op);
        sgn = (op == LD_B) || (op == LD_H) || (op == LD_W);
        v = '0;
        for (int i = 0; i < n; i++)
            if (off + i < DW / 8)
                v[i*8 +: 8] = data[(off+i)*8 +: 8];
        if (sgn && v[n*8-1])
            for (int b = n * 8; b < 64; b++) v[b] = 1'b1;
        return v[DW-1:0];
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_to_wb_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got valid pc %0h expected none",
                             bus.mem_to_wb_pc);
                end else begin
                    e = q[0];
                    chk("wb_pc", bus.mem_to_wb_pc, e.pc);
                    chk("wb_we", bus.mem_to_wb_we, e.we);
                    chk("wb_waddr", bus.mem_to_wb_waddr, e.waddr);
                    chk("wb_wdata", bus.mem_to_wb_wdata, e.wdata);
                    if (bus.wb_allowin) void'(q.pop_front());
                end
            end
        end
    end

    bit occ, req, owed, drain, hv, did_rst;
    bit ok, wb, fl, exp_v, exp_a, acc, tail;
    int cnt, off;
    logic          s_we, p_we, p_req;
    logic [4:0]    s_waddr, p_waddr;
    logic [2:0]    p_op;
    logic [PW-1:0] p_pc;
    logic [DW-1:0] p_alu, p_rdata, cur_rd, tmp;
    exp_t ne;

    initial begin : driver
        bus.ex_to_mem_valid = 1'b0;
        bus.ex_rf_we = 1'b0;
        bus.ex_rf_waddr = '0;
        bus.ex_pc = '0;
        bus.ex_alu_result = '0;
        bus.ex_ld_op = LD_NONE;
        bus.ex_req_sent = 1'b0;
        bus.mem_flush = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata = '0;
        bus.wb_allowin = 1'b1;
        e_valid = 1'b0; e_ok = 1'b0; e_req = 1'b0;
        e_op = LD_NONE; e_alu = '0; e_rdata = '0;
        #1;
        chk("rst_valid", bus.mem_to_wb_valid, 1'b0);
        chk("rst_allowin", bus.mem_allowin, 1'b1);
        chk("rst_zip", bus.mem_rf_zip, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge clk);
            #1;
            tail = (cyc >= NCYC - 40);
            // Drop reset while the slot holds buffered load data
            if (!did_rst && cyc > 1500 && occ && req && !owed) begin
                did_rst = 1;
                resetn = 1'b0;
                #1;
                chk("hold_rst_valid", bus.mem_to_wb_valid, 1'b0);
                chk("hold_rst_allowin", bus.mem_allowin, 1'b1);
                chk("hold_rst_zip", bus.mem_rf_zip, '0);
                occ = 0; owed = 0; drain = 0; req = 0;
                q.delete();
            end
            ok = 0;
            tmp = $urandom();
            if (owed || drain) begin
                if (cnt == 0) begin
                    ok = 1;
                    if (owed) tmp = cur_rd;
                end else cnt--;
            end else if ((!occ || !req) &&
                         $urandom_range(0, 19) == 0) ok = 1;
            wb = tail || ($urandom_range(0, 9) < 7);
            fl = 0;
            if (!tail) begin
                if (owed && !ok)
                    fl = ($urandom_range(0, 5) == 0);
                else if (drain && !ok)
                    fl = ($urandom_range(0, 3) == 0);
                else if (!occ && !drain)
                    fl = ($urandom_range(0, 19) == 0);
            end
            if (!hv && !tail && $urandom_range(0, 9) < 6) begin
                hv = 1;
                p_op = 3'($urandom_range(0, 5));
                off = $urandom_range(0, 3);
                if (p_op != LD_NONE)
                    off = (off / op_bytes(p_op)) * op_bytes(p_op);
                p_alu = $urandom();
                p_alu[1:0] = 2'(off);
                p_we = 1'($urandom_range(0, 1));
                p_waddr = 5'($urandom_range(0, 31));
                p_pc = $urandom();
                p_req = (p_op != LD_NONE) ||
                        ($urandom_range(0, 4) == 0);
                p_rdata = $urandom();
            end
            bus.ex_to_mem_valid = hv;
            bus.ex_rf_we = p_we;
            bus.ex_rf_waddr = p_waddr;
            bus.ex_pc = p_pc;
            bus.ex_alu_result = p_alu;
            bus.ex_ld_op = p_op;
            bus.ex_req_sent = p_req;
            bus.mem_flush = fl;
            bus.data_sram_data_ok = ok;
            bus.data_sram_rdata = tmp;
            bus.wb_allowin = wb;

            @(negedge clk);
            exp_v = occ && (!owed || ok);
            exp_a = (!occ && !drain) || (exp_v && wb);
            chk("valid", bus.mem_to_wb_valid, exp_v);
            chk("allowin", bus.mem_allowin, exp_a);
            if (occ) begin
                chk("zip_we", bus.mem_rf_zip[DW+6], s_we);
                chk("zip_pend", bus.mem_rf_zip[DW+5], req);
                chk("zip_waddr", bus.mem_rf_zip[DW+4:DW], s_waddr);
            end else begin
                chk("zip_idle", bus.mem_rf_zip, '0);
            end
            if (!resetn) resetn = 1'b1;
            acc = hv && exp_a && !fl;
            if (fl) begin
                if (occ && owed) begin
                    void'(q.pop_back());
                    drain = 1;
                    owed = 0;
                end
                occ = 0;
            end else begin
                if (drain && ok) drain = 0;
                if (occ && owed && ok) owed = 0;
                if (exp_v && wb) occ = 0;
                if (acc) begin
                    occ = 1;
                    req = p_req;
                    owed = p_req;
                    cnt = $urandom_range(0, 3);
                    cur_rd = p_rdata;
                    s_we = p_we;
                    s_waddr = p_waddr;
                    ne.we = p_we;
                    ne.waddr = p_waddr;
                    ne.pc = p_pc;
                    ne.wdata = (p_op != LD_NONE) ?
                        ld_model(p_op, p_rdata, int'(p_alu[1:0])) :
                        p_alu;
                    q.push_back(ne);
                    hv = 0;
                end
            end
        end
        chk("scoreboard_empty", q.size(), 0);
        chk("reset_in_hold_seen", did_rst, 1'b1);

        for (int k = 0; k < 5; k++) begin
            logic [2:0]  t_op;
            logic [63:0] t_alu, t_rd, t_exp;
            case (k)
                0: begin t_op = LD_W;  t_alu = 64'h4;
                   t_rd = 64'h8000_0001_1234_5678;
                   t_exp = 64'hFFFF_FFFF_8000_0001; end
                1: begin t_op = LD_WU; t_alu = 64'h4;
                   t_rd = 64'h8000_0001_1234_5678;
                   t_exp = 64'h0000_0000_8000_0001; end
                2: begin t_op = LD_B;  t_alu = 64'h7;
                   t_rd = 64'h80FF_0000_0000_0000;
                   t_exp = 64'hFFFF_FFFF_FFFF_FF80; end
                3: begin t_op = LD_D;  t_alu = 64'h8;
                   t_rd = 64'h0123_4567_89AB_CDEF;
                   t_exp = 64'h0123_4567_89AB_CDEF; end
                default: begin t_op = LD_HU; t_alu = 64'h6;
                   t_rd = 64'hBEEF_0000_0000_0000;
                   t_exp = 64'h0000_0000_0000_BEEF; end
            endcase
            @(posedge clk); #1;
            e_valid = 1'b1; e_op = t_op; e_alu = t_alu;
            e_req = 1'b1; e_ok = 1'b0;
            @(negedge clk);
            chk("d64_allowin", o_allow, 1'b1);
            @(posedge clk); #1;
            e_valid = 1'b0; e_ok = 1'b1; e_rdata = t_rd;
            @(negedge clk);
            chk("d64_valid", o_valid, 1'b1);
            chk("d64_wdata", o_wdata, t_exp);
            chk("d64_pend", o_zip[69], 1'b1);
            @(posedge clk); #1;
            e_ok = 1'b0;
            @(negedge clk);
            chk("d64_idle", o_valid, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
